// File: rtl/clint_multi_apb_if.sv
// APB slave bus bundle for the multi-hart CLINT.
// XLEN selects the data width (32 or 64); strobes are XLEN/8 bits wide.
interface clint_multi_apb_if #(
    parameter int XLEN = 64
);
    logic                PSEL;
    logic [15:0]         PADDR;
    logic [XLEN-1:0]     PWDATA;
    logic [XLEN/8-1:0]   PSTRB;
    logic                PWRITE;
    logic                PENABLE;
    logic [XLEN-1:0]     PRDATA;
    logic                PREADY;

    modport master (
        output PSEL, PADDR, PWDATA, PSTRB, PWRITE, PENABLE,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PSEL, PADDR, PWDATA, PSTRB, PWRITE, PENABLE,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/clint_multi_apb.sv
// Multi-hart core-local interruptor on APB.
// One shared 64-bit MTIME advanced by a TICKDIV prescaler, plus per-hart
// MSIP and MTIMECMP registers driving software and timer interrupt lines.
// Optional macro CLINT_SSWI_EN adds per-hart SETSSIP registers at 0xC000+4h
// driving SSwInt; without it SSwInt is tied low and the region reads 0.
// All register byte lanes are decoded generically from their byte address,
// so the same logic serves XLEN=32 and XLEN=64.
module clint_multi_apb #(
    parameter int XLEN    = 64,
    parameter int NHARTS  = 1,
    parameter int TICKDIV = 1
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    clint_multi_apb_if.slave     apb,
    output logic [63:0]          MTIME,
    output logic [NHARTS-1:0]    MTimerInt,
    output logic [NHARTS-1:0]    MSwInt,
    output logic [NHARTS-1:0]    SSwInt
);
    localparam int              BPW        = XLEN / 8;
    localparam int              LB         = $clog2(BPW);
    localparam logic [15:0]     ENTRY_MASK = ~16'(BPW - 1);
    localparam logic [15:0]     MTIME_ADDR = 16'hBFF8;

    logic            wr_en;
    logic [15:0]     addr_al;

    assign wr_en      = apb.PSEL & apb.PWRITE & apb.PENABLE;
    assign addr_al    = apb.PADDR & ENTRY_MASK;
    assign apb.PREADY = 1'b1;

    logic [15:0]     presc_q, presc_d;
    logic            tick;
    logic [63:0]     mtime_q, mtime_d, mtime_wdata;
    logic            mtime_wr;
    logic [15:0]     m_addr;
    logic [LB-1:0]   m_lane;
    logic [XLEN-1:0] mtime_rd;
    logic [XLEN-1:0] prdata_q, prdata_d;
    logic [XLEN-1:0] hart_rd [NHARTS];

    // Prescaler: free-running 0..TICKDIV-1, tick on the terminal count.
    always_comb begin
        tick    = (presc_q == 16'(TICKDIV - 1));
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
    end

    // MTIME byte decode: bus writes win over the tick increment.
    always_comb begin
        mtime_wr    = 1'b0;
        mtime_wdata = mtime_q;
        mtime_rd    = '0;
        m_addr      = '0;
        m_lane      = '0;
        for (int b = 0; b < 8; b++) begin
            m_addr = MTIME_ADDR + 16'(b);
            if ((m_addr & ENTRY_MASK) == addr_al) begin
                m_lane = m_addr[LB-1:0];
                mtime_rd[8*m_lane +: 8] = mtime_q[8*b +: 8];
                if (wr_en && apb.PSTRB[m_lane]) begin
                    mtime_wdata[8*b +: 8] = apb.PWDATA[8*m_lane +: 8];
                    mtime_wr              = 1'b1;
                end
            end
        end
        mtime_d = mtime_wr ? mtime_wdata : (tick ? mtime_q + 64'd1 : mtime_q);
    end

    // Read mux: every decoded source ORs into its own lanes.
    always_comb begin
        prdata_d = mtime_rd;
        for (int h = 0; h < NHARTS; h++) begin
            prdata_d = prdata_d | hart_rd[h];
        end
    end

    // Shared timebase and registered read data.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            presc_q  <= '0;
            mtime_q  <= '0;
            prdata_q <= '0;
        end else begin
            presc_q  <= presc_d;
            mtime_q  <= mtime_d;
            prdata_q <= prdata_d;
        end
    end

    assign MTIME      = mtime_q;
    assign apb.PRDATA = prdata_q;

    genvar gi;
    generate
        for (gi = 0; gi < NHARTS; gi++) begin : g_hart
            localparam logic [15:0] CMP_BASE  = 16'h4000 + 16'(8 * gi);
            localparam logic [15:0] MSIP_ADDR = 16'(4 * gi);
            localparam int          MSIP_LANE = (4 * gi) % BPW;

            logic [63:0]     cmp_q, cmp_d;
            logic            msip_q, msip_d;
            logic            mtip_q;
            logic [15:0]     c_addr;
            logic [LB-1:0]   c_lane;
            logic [XLEN-1:0] rd;
            logic [XLEN-1:0] ssip_rd;

            // MTIMECMP byte lanes and MSIP bit 0 decode for this hart.
            always_comb begin
                cmp_d  = cmp_q;
                msip_d = msip_q;
                rd     = '0;
                c_addr = '0;
                c_lane = '0;
                for (int b = 0; b < 8; b++) begin
                    c_addr = CMP_BASE + 16'(b);
                    if ((c_addr & ENTRY_MASK) == addr_al) begin
                        c_lane = c_addr[LB-1:0];
                        rd[8*c_lane +: 8] = cmp_q[8*b +: 8];
                        if (wr_en && apb.PSTRB[c_lane]) begin
                            cmp_d[8*b +: 8] = apb.PWDATA[8*c_lane +: 8];
                        end
                    end
                end
                if ((MSIP_ADDR & ENTRY_MASK) == addr_al) begin
                    rd[8*MSIP_LANE] = msip_q;
                    if (wr_en && apb.PSTRB[MSIP_LANE]) begin
                        msip_d = apb.PWDATA[8*MSIP_LANE];
                    end
                end
            end

            // Per-hart state; timer compare uses this cycle's register values.
            always_ff @(posedge PCLK) begin
                if (PRESET) begin
                    cmp_q  <= '1;
                    msip_q <= 1'b0;
                    mtip_q <= 1'b0;
                end else begin
                    cmp_q  <= cmp_d;
                    msip_q <= msip_d;
                    mtip_q <= (mtime_q >= cmp_q);
                end
            end

`ifdef CLINT_SSWI_EN
            localparam logic [15:0] SSIP_ADDR = 16'hC000 + 16'(4 * gi);
            localparam int          SSIP_LANE = (4 * gi) % BPW;

            logic ssip_q, ssip_d;

            // SETSSIP bit 0: plain read/write flag.
            always_comb begin
                ssip_d  = ssip_q;
                ssip_rd = '0;
                if ((SSIP_ADDR & ENTRY_MASK) == addr_al) begin
                    ssip_rd[8*SSIP_LANE] = ssip_q;
                    if (wr_en && apb.PSTRB[SSIP_LANE]) begin
                        ssip_d = apb.PWDATA[8*SSIP_LANE];
                    end
                end
            end

            // Supervisor software interrupt flop.
            always_ff @(posedge PCLK) begin
                if (PRESET) begin
                    ssip_q <= 1'b0;
                end else begin
                    ssip_q <= ssip_d;
                end
            end

            assign SSwInt[gi] = ssip_q;
`else
            assign ssip_rd    = '0;
            assign SSwInt[gi] = 1'b0;
`endif

            assign hart_rd[gi]   = rd | ssip_rd;
            assign MTimerInt[gi] = mtip_q;
            assign MSwInt[gi]    = msip_q;
        end
    endgenerate
endmodule
